// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor: result = a - b.
// Aligns and normalizes one bit per cycle; start/done handshake.
module fp_subtractor_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned W  = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 24;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ARITH = 2'd2,
    NORM  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] m_l_q, m_l_d;
  logic [MW-1:0] m_s_q, m_s_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          sign_q, sign_d;
  logic          sub_q, sub_d;
  logic          busy_d, done_d;
  logic [W-1:0]  result_d;

  logic          a_is_l;
  logic          b_sign_eff;
  logic [MW-1:0] a_mant, b_mant;
  logic [MW-1:0] l_mant_in, s_mant_in;
  logic [EW-1:0] l_exp_in, s_exp_in, exp_diff;
  logic [CW-1:0] shift_in;
  logic          sign_in, sub_in;
  logic [MW:0]   sum_c;

  // Operand decode: flush denormals, order by magnitude, derive shift count.
  always_comb begin
    b_sign_eff = ~b[31];
    a_is_l     = (a[30:0] >= b[30:0]);
    a_mant     = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    b_mant     = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    sub_in     = a[31] ^ b_sign_eff;
    if (a_is_l) begin
      l_exp_in  = a[30:23];
      s_exp_in  = b[30:23];
      l_mant_in = a_mant;
      s_mant_in = b_mant;
      sign_in   = a[31];
    end else begin
      l_exp_in  = b[30:23];
      s_exp_in  = a[30:23];
      l_mant_in = b_mant;
      s_mant_in = a_mant;
      sign_in   = b_sign_eff;
    end
    exp_diff = l_exp_in - s_exp_in;
    if (s_exp_in == 8'd0) begin
      shift_in = 5'd0;
    end else if (exp_diff > 8'd24) begin
      shift_in = 5'd24;
    end else begin
      shift_in = exp_diff[CW-1:0];
    end
  end

  // Magnitude add or subtract of the aligned mantissas; L >= S so no borrow.
  always_comb begin
    if (sub_q) begin
      sum_c = {1'b0, m_l_q} - {1'b0, m_s_q};
    end else begin
      sum_c = {1'b0, m_l_q} + {1'b0, m_s_q};
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_l_d    = m_l_q;
    m_s_d    = m_s_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    done_d   = 1'b0;
    result_d = result;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_l_d   = l_mant_in;
          m_s_d   = s_mant_in;
          exp_d   = l_exp_in;
          sign_d  = sign_in;
          sub_d   = sub_in;
          cnt_d   = shift_in;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt_q == 5'd0) begin
          state_d = ARITH;
        end else begin
          m_s_d = {1'b0, m_s_q[MW-1:1]};
          cnt_d = cnt_q - 5'd1;
        end
      end
      ARITH: begin
        if (sum_c[MW]) begin
          m_l_d = sum_c[MW:1];
          exp_d = exp_q + 8'd1;
        end else begin
          m_l_d = sum_c[MW-1:0];
        end
        state_d = NORM;
      end
      NORM: begin
        if (m_l_q == 24'd0) begin
          result_d = 32'h0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (m_l_q[MW-1]) begin
          if (exp_q == 8'hFF) begin
            result_d = {sign_q, 8'hFF, 23'd0};
          end else begin
            result_d = {sign_q, exp_q, m_l_q[MW-2:0]};
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (exp_q == 8'd1) begin
          result_d = 32'h0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          m_l_d = {m_l_q[MW-2:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_l_q   <= '0;
      m_s_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_l_q   <= m_l_d;
      m_s_q   <= m_s_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: vector table plus control sequences.
module tb_fp_subtractor_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          k;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int   edge_cnt = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];

  fp_subtractor_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  // Scoreboard: every done pulse is matched against the oldest expected op.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done result=%h", result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res) begin
          fails++;
          $display("FAIL result op%0d got=%h exp=%h", mon_e.id, result, mon_e.res);
        end
        checks++;
        if (edge_cnt - mon_e.k != mon_e.lat) begin
          fails++;
          $display("FAIL latency op%0d got=%0d exp=%0d", mon_e.id, edge_cnt - mon_e.k, mon_e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] res,
                        input int lat, input int id);
    @(negedge clk);
    a     = ta;
    b     = tb_;
    start = 1'b1;
    sb.push_back('{res: res, lat: lat, k: edge_cnt + 1, id: id});
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int cnt;
    int k1;

    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 4};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 3};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 3};
    vecs[3]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 5};
    vecs[4]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 27};
    vecs[5]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3};
    vecs[6]  = '{32'h00000000, 32'h40A00000, 32'hC0A00000, 3};
    vecs[7]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 27};
    vecs[8]  = '{32'h5F800000, 32'h3F800000, 32'h5F800000, 27};
    vecs[9]  = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 4};
    vecs[10] = '{32'h00000000, 32'h00000000, 32'h00000000, 3};
    vecs[11] = '{32'h00800000, 32'h00C00000, 32'h00000000, 3};
    vecs[12] = '{32'h3F800000, 32'h80000000, 32'h3F800000, 3};
    vecs[13] = '{32'h40000000, 32'hBF800000, 32'h40400000, 4};

    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i);
      drain();
    end

    // busy spans exactly the operation and is low in the done cycle
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, 100);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      if (busy) cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cnt), 32'd4);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    drain();

    // start while busy is ignored
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, 101);
    @(negedge clk);
    a     = 32'h3F800000;
    b     = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    check("ignored_start_result", result, 32'h40000000);

    // held start gives back-to-back operations
    @(negedge clk);
    a     = 32'h40400000;
    b     = 32'h3F800000;
    start = 1'b1;
    k1    = edge_cnt + 1;
    sb.push_back('{res: 32'h40000000, lat: 4, k: k1, id: 102});
    sb.push_back('{res: 32'h40000000, lat: 4, k: k1 + 5, id: 103});
    repeat (6) @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-ALIGN aborts with no done pulse
    @(negedge clk);
    a     = 32'h4B000000;
    b     = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, 104);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
